// File: rtl/seq_multiplier_n.sv
// seq_multiplier_n: WIDTH-bit sequential shift-add multiplier with a run-time
// unsigned / two's-complement mode and an St/Idle/Done handshake.
// Each RUN edge performs one combined add(or subtract)-and-shift step.
// Optional macro SEQ_MULT_EARLY_TERM_EN: in unsigned mode, finish early with a
// single barrel shift once the remaining multiplier bits are all zero.
module seq_multiplier_n #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 St,
    input  logic                 Signed,
    input  logic [WIDTH-1:0]     Multiplicando,
    input  logic [WIDTH-1:0]     Multiplicador,
    output logic                 Idle,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Produto
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [WIDTH:0]      a_q;
    logic [WIDTH-1:0]    q_q;
    logic [WIDTH-1:0]    m_q;
    logic [CW-1:0]       cnt_q;
    logic                sm_q;
    logic                idle_q;
    logic                done_q;
    logic [2*WIDTH-1:0]  prod_q;

    logic [WIDTH:0]      mext;
    logic [WIDTH:0]      a_sum;
    logic [WIDTH:0]      a_d;
    logic [WIDTH-1:0]    q_d;
    logic [CW-1:0]       cnt_d;
    logic                last_step;
    logic                fill;
`ifdef SEQ_MULT_EARLY_TERM_EN
    logic [WIDTH:0]      mask_w;
    logic                early_hit;
`endif

    // Next {A,Q,cnt} for one RUN step
    always_comb begin
        mext      = {sm_q & m_q[WIDTH-1], m_q};
        last_step = (cnt_q == CW'(1));
        if (q_q[0]) begin
            // Signed mode: the multiplier's MSB carries weight -2^(WIDTH-1)
            a_sum = (last_step && sm_q) ? (a_q - mext) : (a_q + mext);
        end else begin
            a_sum = a_q;
        end
        fill  = sm_q & a_sum[WIDTH];
        a_d   = {fill, a_sum[WIDTH:1]};
        q_d   = {a_sum[0], q_q[WIDTH-1:1]};
        cnt_d = cnt_q - CW'(1);
`ifdef SEQ_MULT_EARLY_TERM_EN
        mask_w    = ((WIDTH+1)'(1) << cnt_q) - (WIDTH+1)'(1);
        early_hit = !sm_q && ((q_q & mask_w[WIDTH-1:0]) == '0);
        if (early_hit) begin
            // Remaining steps would only shift; collapse them into one shift
            {a_d, q_d} = {a_q, q_q} >> cnt_q;
            cnt_d      = '0;
        end
`endif
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            sm_q    <= 1'b0;
            idle_q  <= 1'b1;
            done_q  <= 1'b0;
            prod_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (St) begin
                        a_q     <= '0;
                        q_q     <= Multiplicador;
                        m_q     <= Multiplicando;
                        sm_q    <= Signed;
                        cnt_q   <= CW'(WIDTH);
                        idle_q  <= 1'b0;
                        state_q <= S_RUN;
                    end else begin
                        idle_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_d;
                    if (cnt_d == '0) begin
                        prod_q  <= {a_d[WIDTH-1:0], q_d};
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    idle_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    idle_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Idle    = idle_q;
    assign Done    = done_q;
    assign Produto = prod_q;

endmodule

// File: tb/tb_seq_multiplier_n.sv
// Directed self-checking bench for seq_multiplier_n at WIDTH = 8.
module tb_seq_multiplier_n;

    localparam int unsigned W = 8;

    logic           Clk = 1'b0;
    logic           Rst;
    logic           St;
    logic           Signed;
    logic [W-1:0]   Multiplicando;
    logic [W-1:0]   Multiplicador;
    logic           Idle;
    logic           Done;
    logic [2*W-1:0] Produto;

    int checks = 0;
    int errors = 0;

    seq_multiplier_n #(.WIDTH(W)) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .St            (St),
        .Signed        (Signed),
        .Multiplicando (Multiplicando),
        .Multiplicador (Multiplicador),
        .Idle          (Idle),
        .Done          (Done),
        .Produto       (Produto)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected RUN edges from E0 to the edge that raises Done
    function automatic int exp_lat(input logic [W-1:0] b, input logic s);
        int lat;
        lat = W;
`ifdef SEQ_MULT_EARLY_TERM_EN
        if (!s) begin
            lat = 1;
            for (int i = 0; i < W; i++)
                if (b[i]) lat = (i + 2 > W) ? W : i + 2;
        end
`endif
        return lat;
    endfunction

    // Waits for Done after E0, returns the number of edges taken (0 on timeout)
    task automatic wait_done(output int n);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (Done === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [15:0] exp_p);
        int n;
        Multiplicando = a;
        Multiplicador = b;
        Signed        = s;
        St            = 1'b1;
        tick();                         // E0
        St = 1'b0;
        check({tag, "_idle_low"}, 32'(Idle), 32'd0);
        wait_done(n);
        check({tag, "_latency"}, 32'(n), 32'(exp_lat(b, s)));
        check({tag, "_prod"}, 32'(Produto), 32'(exp_p));
        tick();
        check({tag, "_done_pulse"}, 32'(Done), 32'd0);
        check({tag, "_idle_back"}, 32'(Idle), 32'd1);
    endtask

    initial begin
        int n;
        int n2;
        int dones;
        Rst = 1'b1; St = 1'b0; Signed = 1'b0;
        Multiplicando = '0; Multiplicador = '0;
        tick();
        tick();
        check("rst_idle", 32'(Idle), 32'd1);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_prod", 32'(Produto), 32'd0);
        Rst = 1'b0;
        tick();

        run_op("u255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
        run_op("s_m3x5",   8'hFD, 8'h05, 1'b1, 16'hFFF1);
        run_op("s_m128sq", 8'h80, 8'h80, 1'b1, 16'h4000);
        run_op("s127xm1",  8'h7F, 8'hFF, 1'b1, 16'hFF81);
        run_op("u7x3",     8'h07, 8'h03, 1'b0, 16'h0015);
        run_op("u9x0",     8'h09, 8'h00, 1'b0, 16'h0000);
        run_op("s7x3",     8'h07, 8'h03, 1'b1, 16'h0015);
        run_op("u200x100", 8'hC8, 8'h64, 1'b0, 16'h4E20);

        // St pulsed during RUN and operands changed after E0
        Multiplicando = 8'd12; Multiplicador = 8'd11; Signed = 1'b0; St = 1'b1;
        tick();                         // E0
        Multiplicando = 8'hFF; Multiplicador = 8'hFF; Signed = 1'b1;
        tick(); tick();
        St = 1'b0;
        dones = 0;
        n = 0;
        for (int k = 3; k <= 20; k++) begin
            tick();
            if (Done === 1'b1) begin
                dones++;
                if (n == 0) n = k;
            end
        end
        check("ignore_st_latency", 32'(n), 32'(exp_lat(8'd11, 1'b0)));
        check("ignore_st_dones", 32'(dones), 32'd1);
        check("ignore_st_prod", 32'(Produto), 32'd132);

        // Reset asserted at E4 of an operation
        Multiplicando = 8'd5; Multiplicador = 8'd6; Signed = 1'b0; St = 1'b1;
        tick();                         // E0
        St = 1'b0;
        tick(); tick(); tick();         // E1..E3
        Rst = 1'b1;
        tick();                         // E4
        Rst = 1'b0;
        check("abort_idle", 32'(Idle), 32'd1);
        check("abort_done", 32'(Done), 32'd0);
        check("abort_prod", 32'(Produto), 32'd0);
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (Done === 1'b1) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        run_op("after_abort", 8'd13, 8'd13, 1'b0, 16'd169);

        // St held high: back-to-back operations
        Multiplicando = 8'd7; Multiplicador = 8'd3; Signed = 1'b0; St = 1'b1;
        tick();                         // E0
        Multiplicando = 8'd10; Multiplicador = 8'd10;
        wait_done(n);
        check("b2b_first_lat", 32'(n), 32'(exp_lat(8'd3, 1'b0)));
        check("b2b_first_prod", 32'(Produto), 32'd21);
        wait_done(n2);
        check("b2b_spacing", 32'(n2), 32'(exp_lat(8'd10, 1'b0) + 2));
        check("b2b_second_prod", 32'(Produto), 32'd100);
        St = 1'b0;
        tick();
        check("b2b_done_low", 32'(Done), 32'd0);
        for (int k = 0; k < 12; k++) tick();
        check("prod_hold", 32'(Produto), 32'd100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
